// File: rtl/btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, per-channel debounce, registered press/release pulses; BTN_AUTOREPEAT_EN adds held-key repeats.
// Latency: a held raw change reaches BTN_LEVEL/BTN_PRESS/BTN_RELEASE on the (DEBOUNCE_CYCLES+2)th rising edge.
// Backpressure: none; levels and one-cycle pulses are free-running with no handshake.
module btn_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_N,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_conditioner: illegal timing parameter");
    end

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic [N_BTN-1:0] w_sync;
    logic [N_BTN-1:0] w_toggle;
    logic [N_BTN-1:0] w_rpt;

    // Synchronizer resets to "released" so a held button re-debounces after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= BTN_N;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sync = ~r_sync2;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             w_diff;

        assign w_diff       = w_sync[gi] ^ r_level[gi];
        assign w_toggle[gi] = w_diff && (r_cnt == CNT_LAST);

        always_ff @(posedge CLK) begin
            if (RST || !w_diff || w_toggle[gi]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RPT_W   = $clog2(RPT_MAX + 1);

        logic [RPT_W-1:0] r_rpt_cnt;
        logic             r_rpt_first;
        logic             w_rpt_due;

        assign w_rpt_due = r_rpt_first ? (r_rpt_cnt == RPT_W'(REPEAT_DELAY - 1))
                                       : (r_rpt_cnt == RPT_W'(REPEAT_PERIOD - 1));
        // A level change (including release) overrides any repeat due on the same edge.
        assign w_rpt[gi] = r_level[gi] && !w_toggle[gi] && w_rpt_due;

        always_ff @(posedge CLK) begin
            if (RST || w_toggle[gi]) begin
                r_rpt_cnt   <= '0;
                r_rpt_first <= 1'b1;
            end else if (r_level[gi]) begin
                if (w_rpt_due) begin
                    r_rpt_cnt   <= '0;
                    r_rpt_first <= 1'b0;
                end else begin
                    r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                end
            end
        end
`else
        assign w_rpt[gi] = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_level   <= r_level ^ w_toggle;
            r_press   <= (w_toggle & ~r_level) | w_rpt;
            r_release <= w_toggle & r_level;
        end
    end

    assign BTN_LEVEL   = r_level;
    assign BTN_PRESS   = r_press;
    assign BTN_RELEASE = r_release;

endmodule
